// File: rtl/flag_gen_sequencer.sv
// Frame-level controller for flag_generator: accepts and validates one image
// configuration, holds it for the frame, meters one frame of samples in, then waits for last_i.
module flag_gen_sequencer #(
  parameter int unsigned DATA_WIDTH           = 16,
  parameter int unsigned MAX_BLOCK_SAMPLE_LOG = 4,
  parameter int unsigned MAX_BLOCK_LINE_LOG   = 4,
  parameter int unsigned MAX_IMAGE_SAMPLE_LOG = 12,
  parameter int unsigned MAX_IMAGE_LINE_LOG   = 12,
  parameter int unsigned MAX_IMAGE_BAND_LOG   = 12
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [MAX_BLOCK_SAMPLE_LOG-1:0] cfg_block_samples,
  input  logic [MAX_BLOCK_LINE_LOG-1:0]   cfg_block_lines,
  input  logic [MAX_IMAGE_SAMPLE_LOG-1:0] cfg_image_samples,
  input  logic [MAX_IMAGE_LINE_LOG-1:0]   cfg_image_lines,
  input  logic [MAX_IMAGE_BAND_LOG-1:0]   cfg_image_bands,

  output logic [MAX_BLOCK_SAMPLE_LOG-1:0] config_block_samples,
  output logic [MAX_BLOCK_LINE_LOG-1:0]   config_block_lines,
  output logic [MAX_IMAGE_SAMPLE_LOG-1:0] config_image_samples,
  output logic [MAX_IMAGE_LINE_LOG-1:0]   config_image_lines,
  output logic [MAX_IMAGE_BAND_LOG-1:0]   config_image_bands,

  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,

  output logic [DATA_WIDTH-1:0]           fg_input_data,
  output logic                            fg_input_valid,
  input  logic                            fg_input_ready,

  input  logic                            fg_output_valid,
  input  logic                            fg_output_ready,
  input  logic                            fg_output_last_i,

  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int unsigned TOTAL_W =
    MAX_IMAGE_SAMPLE_LOG + MAX_IMAGE_LINE_LOG + MAX_IMAGE_BAND_LOG + 1;
  localparam logic [TOTAL_W-1:0] ONE = {{(TOTAL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FEED,
    WAIT_OUT
  } state_t;

  state_t             state;
  logic [TOTAL_W-1:0] total;
  logic [TOTAL_W-1:0] in_count;
  logic [TOTAL_W-1:0] frame_size;
  logic               cfg_ok;
  logic               in_hs;
  logic               last_hs;

  // Validation and sizing use the latched config so the upstream bus may move after the handshake.
  assign cfg_ok = (TOTAL_W'(config_block_samples) <= TOTAL_W'(config_image_samples)) &&
                  (TOTAL_W'(config_block_lines)   <= TOTAL_W'(config_image_lines));

  assign frame_size = (TOTAL_W'(config_image_samples) + ONE) *
                      (TOTAL_W'(config_image_lines)   + ONE) *
                      (TOTAL_W'(config_image_bands)   + ONE);

  assign in_hs   = (state == FEED) && in_valid && fg_input_ready;
  assign last_hs = fg_output_valid && fg_output_ready && fg_output_last_i;

  // Input path is a zero-latency gate: open only while the frame is being fed.
  assign cfg_ready      = (state == IDLE);
  assign in_ready       = (state == FEED) && fg_input_ready;
  assign fg_input_valid = (state == FEED) && in_valid;
  assign fg_input_data  = in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      config_block_samples <= '0;
      config_block_lines   <= '0;
      config_image_samples <= '0;
      config_image_lines   <= '0;
      config_image_bands   <= '0;
      total                <= '0;
      in_count             <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            config_block_samples <= cfg_block_samples;
            config_block_lines   <= cfg_block_lines;
            config_image_samples <= cfg_image_samples;
            config_image_lines   <= cfg_image_lines;
            config_image_bands   <= cfg_image_bands;
            state                <= CHECK;
            busy                 <= 1'b1;
          end
        end
        CHECK: begin
          if (cfg_ok) begin
            total    <= frame_size;
            in_count <= '0;
            state    <= FEED;
          end else begin
            error <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        FEED: begin
          // An early last_i means the generator is out of step with this frame.
          if (last_hs) begin
            error <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (in_hs) begin
            in_count <= in_count + ONE;
            if (in_count == total - ONE) begin
              state <= WAIT_OUT;
            end
          end
        end
        WAIT_OUT: begin
          if (last_hs) begin
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_gen_sequencer.sv
// Directed bench for flag_gen_sequencer: a frame-level model is compared against
// the outputs every cycle, plus hand-computed literal checks per scenario.
module tb_flag_gen_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_block_samples = '0, cfg_block_lines = '0;
  logic [11:0] cfg_image_samples = '0, cfg_image_lines = '0, cfg_image_bands = '0;
  logic [3:0]  config_block_samples, config_block_lines;
  logic [11:0] config_image_samples, config_image_lines, config_image_bands;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] fg_input_data;
  logic        fg_input_valid;
  logic        fg_input_ready = 1'b0;
  logic        fg_output_valid = 1'b0, fg_output_ready = 1'b0, fg_output_last_i = 1'b0;
  logic        busy, done, error;

  flag_gen_sequencer #(
    .DATA_WIDTH(16), .MAX_BLOCK_SAMPLE_LOG(4), .MAX_BLOCK_LINE_LOG(4),
    .MAX_IMAGE_SAMPLE_LOG(12), .MAX_IMAGE_LINE_LOG(12), .MAX_IMAGE_BAND_LOG(12)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_block_samples(cfg_block_samples), .cfg_block_lines(cfg_block_lines),
    .cfg_image_samples(cfg_image_samples), .cfg_image_lines(cfg_image_lines),
    .cfg_image_bands(cfg_image_bands),
    .config_block_samples(config_block_samples), .config_block_lines(config_block_lines),
    .config_image_samples(config_image_samples), .config_image_lines(config_image_lines),
    .config_image_bands(config_image_bands),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fg_input_data(fg_input_data), .fg_input_valid(fg_input_valid),
    .fg_input_ready(fg_input_ready),
    .fg_output_valid(fg_output_valid), .fg_output_ready(fg_output_ready),
    .fg_output_last_i(fg_output_last_i),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: 0 = waiting for config, 1 = validating, 2 = streaming, 3 = draining.
  int          m_phase = 0;
  logic [3:0]  m_bs = '0, m_bl = '0;
  logic [11:0] m_is = '0, m_il = '0, m_ib = '0;
  longint      m_total = 0, m_cnt = 0;
  bit          m_done = 1'b0, m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_bs <= '0; m_bl <= '0; m_is <= '0; m_il <= '0; m_ib <= '0;
      m_total <= 0; m_cnt <= 0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (m_phase == 0) begin
        if (cfg_valid) begin
          m_bs <= cfg_block_samples; m_bl <= cfg_block_lines;
          m_is <= cfg_image_samples; m_il <= cfg_image_lines; m_ib <= cfg_image_bands;
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        if (m_bs > m_is || m_bl > m_il) begin
          m_err <= 1'b1;
          m_phase <= 0;
        end else begin
          m_total <= (longint'(m_is) + 1) * (longint'(m_il) + 1) * (longint'(m_ib) + 1);
          m_cnt <= 0;
          m_phase <= 2;
        end
      end else if (m_phase == 2) begin
        if (fg_output_valid && fg_output_ready && fg_output_last_i) begin
          m_err <= 1'b1;
          m_phase <= 0;
        end else if (in_valid && fg_input_ready) begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_total) m_phase <= 3;
        end
      end else begin
        if (fg_output_valid && fg_output_ready && fg_output_last_i) begin
          m_done <= 1'b1;
          m_phase <= 0;
        end
      end
    end
  end

  // Compare + monitor process: checks every cycle, records words that reached the generator.
  bit          cmp_en = 1'b0;
  bit          hs_seen = 1'b0;
  logic [15:0] fed_q[$];
  int          done_cnt = 0, err_cnt = 0;

  initial forever begin
    @(negedge clk);
    hs_seen = in_valid && in_ready;
    if (fg_input_valid && fg_input_ready) fed_q.push_back(fg_input_data);
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (cmp_en) begin
      check("cfg_ready", cfg_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("in_ready", in_ready, (m_phase == 2) && fg_input_ready);
      check("fg_input_valid", fg_input_valid, (m_phase == 2) && in_valid);
      check("fg_input_data", fg_input_data, in_data);
      check("done", done, m_done);
      check("error", error, m_err);
      check("done_and_error", done && error, 0);
      check("config_block_samples", config_block_samples, m_bs);
      check("config_block_lines", config_block_lines, m_bl);
      check("config_image_samples", config_image_samples, m_is);
      check("config_image_lines", config_image_lines, m_il);
      check("config_image_bands", config_image_bands, m_ib);
    end
  end

  // Upstream source: offers words feed_w, feed_w+1, ... below feed_lim while enabled.
  bit feed_en = 1'b0;
  int feed_lim = 0;
  int feed_w = 0;

  initial forever begin
    @(posedge clk);
    if (!feed_en) feed_w = 0;
    else if (hs_seen) feed_w++;
    #1;
    in_valid = feed_en && (feed_w < feed_lim);
    in_data  = 16'(feed_w);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] bs, input logic [3:0] bl,
                        input logic [11:0] img_s, input logic [11:0] img_l,
                        input logic [11:0] img_b);
    cfg_valid = 1'b1;
    cfg_block_samples = bs; cfg_block_lines = bl;
    cfg_image_samples = img_s; cfg_image_lines = img_l; cfg_image_bands = img_b;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_fed(input int base, input int n, input string name);
    int k = 0;
    while ((fed_q.size() - base) < n && k < 400) begin
      tick;
      k++;
    end
    check(name, fed_q.size() - base, n);
  endtask

  task automatic out_last_hs;
    fg_output_valid = 1'b1; fg_output_ready = 1'b1; fg_output_last_i = 1'b1;
    tick;
    fg_output_valid = 1'b0; fg_output_ready = 1'b0; fg_output_last_i = 1'b0;
  endtask

  task automatic source_off;
    feed_en = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, got 1, expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int base, d0, e0, bad;
    bit rdy;

    // Reset held for three cycles.
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick;
    check("rst_config_sum", config_block_samples + config_block_lines + config_image_samples
                            + config_image_lines + config_image_bands, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    tick; tick;
    check("post_rst_busy", busy, 0);
    check("post_rst_cfg_ready", cfg_ready, 1);

    // Nominal 3x3x2 frame with 25 words offered.
    fg_input_ready = 1'b1;
    feed_lim = 25;
    feed_en = 1'b1;
    base = fed_q.size();
    d0 = done_cnt;
    do_cfg(4'd1, 4'd1, 12'd2, 12'd2, 12'd1);
    check("nom_check_in_ready", in_ready, 0);
    tick;
    check("nom_feed_in_ready", in_ready, 1);
    wait_fed(base, 18, "nom_fed_18");
    check("nom_in_ready_after_last", in_ready, 0);
    check("nom_model_total", m_total, 18);
    repeat (3) tick;
    check("nom_still_18", fed_q.size() - base, 18);
    check("nom_word18_waits", in_valid && (in_data == 16'd18), 1);
    bad = 0;
    for (int i = 0; i < 18; i++) if (fed_q[base + i] != 16'(i)) bad++;
    check("nom_words_0_17", bad, 0);
    out_last_hs;
    check("nom_done_pulse", done, 1);
    check("nom_cfg_ready_v1", cfg_ready, 1);
    tick;
    check("nom_done_low", done, 0);
    check("nom_done_count", done_cnt - d0, 1);
    source_off;

    // Rejected config: block_samples 5 > image_samples 2.
    feed_lim = 25;
    feed_en = 1'b1;
    base = fed_q.size();
    e0 = err_cnt;
    do_cfg(4'd5, 4'd0, 12'd2, 12'd0, 12'd0);
    check("rej_t1_error", error, 0);
    tick;
    check("rej_t2_error", error, 1);
    check("rej_t2_cfg_ready", cfg_ready, 1);
    check("rej_cfg_bs_held", config_block_samples, 5);
    tick;
    check("rej_t3_error", error, 0);
    check("rej_no_input", fed_q.size() - base, 0);
    check("rej_err_count", err_cnt - e0, 1);
    source_off;

    // Random backpressure on both generator handshakes.
    feed_lim = 25;
    feed_en = 1'b1;
    base = fed_q.size();
    d0 = done_cnt;
    do_cfg(4'd1, 4'd1, 12'd2, 12'd2, 12'd1);
    for (int k = 0; k < 400 && (fed_q.size() - base) < 18; k++) begin
      fg_input_ready  = 1'($urandom_range(0, 1));
      fg_output_valid = 1'($urandom_range(0, 1));
      fg_output_ready = 1'($urandom_range(0, 1));
      fg_output_last_i = 1'b0;
      tick;
    end
    check("bp_fed_18", fed_q.size() - base, 18);
    fg_input_ready = 1'b1;
    #1;
    check("bp_in_ready_blocked", in_ready, 0);
    for (int k = 0; k < 50; k++) begin
      rdy = (k >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      fg_output_valid = 1'b1; fg_output_ready = rdy; fg_output_last_i = 1'b1;
      tick;
      if (rdy) break;
    end
    fg_output_valid = 1'b0; fg_output_ready = 1'b0; fg_output_last_i = 1'b0;
    check("bp_done_pulse", done, 1);
    tick;
    check("bp_done_count", done_cnt - d0, 1);
    check("bp_fed_final", fed_q.size() - base, 18);
    source_off;

    // Sequence violation: last_i while still feeding.
    fg_input_ready = 1'b1;
    feed_lim = 4;
    feed_en = 1'b1;
    base = fed_q.size();
    do_cfg(4'd1, 4'd1, 12'd2, 12'd2, 12'd1);
    wait_fed(base, 4, "vio_fed_4");
    out_last_hs;
    check("vio_error", error, 1);
    check("vio_busy", busy, 0);
    check("vio_in_ready", in_ready, 0);
    check("vio_cfg_ready", cfg_ready, 1);
    tick;
    check("vio_error_low", error, 0);
    source_off;

    // Reset mid-frame after 10 inputs, then a full frame.
    feed_lim = 25;
    feed_en = 1'b1;
    base = fed_q.size();
    d0 = done_cnt;
    e0 = err_cnt;
    do_cfg(4'd1, 4'd1, 12'd2, 12'd2, 12'd1);
    wait_fed(base, 10, "mrst_fed_10");
    rst = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 0);
    check("mrst_fg_input_valid", fg_input_valid, 0);
    check("mrst_busy", busy, 0);
    tick; tick;
    rst = 1'b1;
    tick;
    check("mrst_no_done", done_cnt - d0, 0);
    check("mrst_no_error", err_cnt - e0, 0);
    source_off;
    feed_en = 1'b1;
    base = fed_q.size();
    do_cfg(4'd1, 4'd1, 12'd2, 12'd2, 12'd1);
    wait_fed(base, 18, "mrst2_fed_18");
    bad = 0;
    for (int i = 0; i < 18; i++) if (fed_q[base + i] != 16'(i)) bad++;
    check("mrst2_words_0_17", bad, 0);
    out_last_hs;
    check("mrst2_done", done, 1);
    tick;
    check("mrst2_done_count", done_cnt - d0, 1);
    source_off;

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flag_gen_sequencer.md
# flag_gen_sequencer

Frame-level controller placed in front of `flag_generator`. It accepts one image configuration at a time through a handshake, checks it, and holds it stable on the generator's `config_*` inputs for the whole frame. It passes exactly one frame's worth of raw samples into the generator, then blocks further input until the generator emits `last_i` on its output. Without it, back-to-back images could enter the generator under a stale configuration.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width
- MAX_BLOCK_SAMPLE_LOG, 4, block-sample config width
- MAX_BLOCK_LINE_LOG, 4, block-line config width
- MAX_IMAGE_SAMPLE_LOG, 12, image-sample config width
- MAX_IMAGE_LINE_LOG, 12, image-line config width
- MAX_IMAGE_BAND_LOG, 12, image-band config width
- Derived TOTAL_W = MAX_IMAGE_SAMPLE_LOG+MAX_IMAGE_LINE_LOG+MAX_IMAGE_BAND_LOG+1, sample-count width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_block_samples / cfg_block_lines  in  MAX_BLOCK_*_LOG  block size, N-1 encoded
- cfg_image_samples / cfg_image_lines / cfg_image_bands  in  MAX_IMAGE_*_LOG  image size, N-1 encoded
- config_block_samples, config_block_lines, config_image_samples, config_image_lines, config_image_bands  out  same widths  to flag_generator
- in_data  in  DATA_WIDTH  upstream sample
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- fg_input_data  out  DATA_WIDTH  to generator raw_input_data
- fg_input_valid  out  1  to raw_input_valid
- fg_input_ready  in  1  from raw_input_ready
- fg_output_valid, fg_output_ready, fg_output_last_i  in  1 each  tap of generator output handshake
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, frame complete
- error  out  1  one-cycle pulse, config rejected or sequence violation

## Operation
- States: IDLE, CHECK, FEED, WAIT_OUT.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, latch all five cfg_* into the config_* registers and go to CHECK.
  - config_* change only on this handshake; they are held through CHECK, FEED and WAIT_OUT.
- CHECK (exactly 1 cycle):
  - valid iff cfg_block_samples<=cfg_image_samples and cfg_block_lines<=cfg_image_lines (N-1 values compared, zero-extended).
  - Register total=(is+1)*(il+1)*(ib+1) in TOTAL_W bits, unsigned; no overflow is possible.
  - Invalid: error pulse, go to IDLE. Valid: clear in_count, go to FEED.
- FEED:
  - fg_input_valid=in_valid, in_ready=fg_input_ready, fg_input_data=in_data (combinational, zero latency).
  - in_count (TOTAL_W) increments on each fg_input_valid&&fg_input_ready.
  - The handshake with in_count==total-1 moves to WAIT_OUT.
  - A fg_output_valid&&fg_output_ready&&fg_output_last_i handshake seen in FEED is a sequence violation: error pulse, go to IDLE.
- WAIT_OUT:
  - fg_input_valid=0, in_ready=0.
  - On output handshake with last_i: done pulse, go to IDLE.
- Outside FEED: fg_input_valid=0, in_ready=0, fg_input_data=in_data.
- cfg_valid outside IDLE is ignored (cfg_ready=0); the offered config stays pending upstream.
- done and error are never high in the same cycle.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, every config_* = 0, in_count=0, total=0.
  - done=0, error=0, busy=0, in_ready=0, fg_input_valid=0.
  - cfg_ready=1 (IDLE); it is also 1 while rst is held low.
- Config handshake at cycle t: CHECK at t+1, FEED at t+2; in_ready may first be high at t+2.
- Config rejected: error=1 at t+2, cfg_ready=1 at t+2.
- Last input handshake at cycle u: WAIT_OUT from u+1, in_ready=0 from u+1.
- last_i output handshake at cycle v: done=1 and cfg_ready=1 at v+1.
- Minimum gap between frames: a new config can be accepted at v+1.
- Reset asserted mid-frame: immediate return to IDLE and input gating, with no done or error. The flag_generator shares rst and is cleared too.

## Test plan
- Reset: hold rst=0 3 cycles -> all config_*=0, busy=0, done=0, error=0, in_ready=0, cfg_ready=1; release -> unchanged until cfg_valid.
- Nominal frame: cfg block 1/1, image 2/2/1 (3x3x2 = 18 samples), generator with LATCH_INPUT=LATCH_OUTPUT=1, upstream offers 25 words 0..24 -> exactly words 0..17 reach the generator, in_ready=0 after word 17, done pulses once after the last_i handshake, words 18..24 wait.
- Reject: cfg block_samples=5, image_samples=2 -> error=1 at t+2 only, no fg_input_valid ever, cfg_ready=1 at t+2, config_block_samples holds 5.
- Backpressure: toggle fg_input_ready and fg_output_ready randomly on the 18-sample frame -> in_count counts handshakes only, 18 total, config_* stable throughout, single done.
- Violation: force fg_output_last_i handshake while in FEED after 4 inputs -> error pulse next cycle, state IDLE, in_ready=0.
- Mid-frame reset: drop rst after 10 of 18 inputs -> in_ready and fg_input_valid go 0 in the same cycle, busy=0, no done; then a new config runs a full 18-sample frame to done.
